// File: rtl/booth_r4_datapath.sv
// Radix-4 Booth multiplier datapath: holds M, A, Q, Q[-1] and the iteration count,
// and performs the strobed add/shift steps under control of an external sequencer.
module booth_r4_datapath #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] inbus,
  input  logic         c0,
  input  logic         c1,
  input  logic         c2,
  input  logic         c3,
  input  logic         c4,
  input  logic         c5,
  input  logic         c6,
  input  logic         c7,
  output logic [2:0]   q_lsb,
  output logic         cnt_done,
  output logic [W-1:0] outbus
);

  localparam int AW   = W + 2;
  localparam int ITER = W / 2;
  localparam int CW   = $clog2(ITER + 1);

  logic        [W-1:0]  m_reg;
  logic signed [AW-1:0] a_reg;
  logic        [W-1:0]  q_reg;
  logic                 q_m1;
  logic        [CW-1:0] cnt;

  logic signed [AW-1:0] x_op;
  logic signed [AW-1:0] a_sum;
  logic signed [AW-1:0] a_shift;
  logic signed [AW-1:0] a_nxt;
  logic        [W-1:0]  q_nxt;
  logic                 q_m1_nxt;
  logic        [CW-1:0] cnt_nxt;

  // Two guard bits on A keep +/-2M of any W-bit M in range.
  function automatic logic signed [AW-1:0] sext_m(input logic [W-1:0] m, input logic dbl);
    logic signed [AW-1:0] ext;
    ext = {{2{m[W-1]}}, m};
    return dbl ? (ext <<< 1) : ext;
  endfunction

  function automatic logic [CW-1:0] cnt_sat_inc(input logic [CW-1:0] c);
    return (c == CW'(ITER)) ? c : c + CW'(1);
  endfunction

  always_comb begin
    x_op     = sext_m(m_reg, c4);
    a_sum    = a_reg;
    if (c2) begin
      a_sum = c3 ? (a_reg - x_op) : (a_reg + x_op);
    end
    a_shift  = a_sum >>> 2;
    a_nxt    = a_reg;
    q_nxt    = q_reg;
    q_m1_nxt = q_m1;
    cnt_nxt  = cnt;
    if (c0) begin
      a_nxt    = '0;
      q_nxt    = inbus;
      q_m1_nxt = 1'b0;
      cnt_nxt  = '0;
    end else if (c5) begin
      // Shift operates on the post-add value so c2+c5 completes in one edge.
      a_nxt    = a_shift;
      q_nxt    = {a_sum[1:0], q_reg[W-1:2]};
      q_m1_nxt = q_reg[1];
      cnt_nxt  = cnt_sat_inc(cnt);
    end else if (c2) begin
      a_nxt = a_sum;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m_reg  <= '0;
      a_reg  <= '0;
      q_reg  <= '0;
      q_m1   <= 1'b0;
      cnt    <= '0;
      outbus <= '0;
    end else begin
      if (c1) begin
        m_reg <= inbus;
      end
      a_reg <= a_nxt;
      q_reg <= q_nxt;
      q_m1  <= q_m1_nxt;
      cnt   <= cnt_nxt;
      // Output bus samples the pre-update registers.
      if (c6) begin
        outbus <= a_reg[W-1:0];
      end else if (c7) begin
        outbus <= q_reg;
      end
    end
  end

  assign q_lsb    = {q_reg[1:0], q_m1};
  assign cnt_done = (cnt == CW'(ITER));

endmodule

// File: tb/tb_booth_r4_datapath.sv
// Directed bench for booth_r4_datapath: an arithmetic reference model checked every
// cycle, plus literal product/flag expectations for hand-worked vectors.
module tb_booth_r4_datapath;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic [W-1:0] inbus;
  logic         c0, c1, c2, c3, c4, c5, c6, c7;
  logic [2:0]   q_lsb;
  logic         cnt_done;
  logic [W-1:0] outbus;

  int n_cmp;
  int n_err;
  bit chk_en;

  booth_r4_datapath #(.W(W)) dut (
    .clk(clk), .reset(reset), .inbus(inbus),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6), .c7(c7),
    .q_lsb(q_lsb), .cnt_done(cnt_done), .outbus(outbus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: A kept as a plain signed integer, shift done on the
  // numeric value of the concatenation {A,Q,Q[-1]}.
  longint       md_a;
  logic [W-1:0] md_m;
  logic [W-1:0] md_q;
  logic         md_qm1;
  int           md_cnt;
  logic [W-1:0] md_ob;

  always @(posedge clk) begin : model
    automatic longint a;
    automatic longint x;
    automatic longint v;
    automatic longint modv;
    if (!reset) begin
      md_a <= 0; md_m <= '0; md_q <= '0; md_qm1 <= 1'b0; md_cnt <= 0; md_ob <= '0;
    end else begin
      modv = longint'(1) << (W + 2);
      a = md_a;
      if (c2) begin
        x = longint'($signed(md_m));
        if (c4) x = 2 * x;
        a = c3 ? a - x : a + x;
        a = ((a % modv) + modv) % modv;
        if (a >= modv / 2) a = a - modv;
      end
      if (c6) md_ob <= md_a[W-1:0];
      else if (c7) md_ob <= md_q;
      if (c1) md_m <= inbus;
      if (c0) begin
        md_a <= 0; md_q <= inbus; md_qm1 <= 1'b0; md_cnt <= 0;
      end else if (c5) begin
        v = a * (longint'(1) << (W + 1)) + longint'(md_q) * 2 + longint'(md_qm1);
        v = v >>> 2;
        md_qm1 <= v[0];
        md_q   <= v[W:1];
        md_a   <= v >>> (W + 1);
        md_cnt <= (md_cnt < W / 2) ? md_cnt + 1 : md_cnt;
      end else begin
        md_a <= a;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      n_cmp++;
      if (outbus !== md_ob) begin
        n_err++;
        $display("FAIL model_outbus t=%0t actual=%h required=%h", $time, outbus, md_ob);
      end
      n_cmp++;
      if (q_lsb !== {md_q[1:0], md_qm1}) begin
        n_err++;
        $display("FAIL model_q_lsb t=%0t actual=%b required=%b", $time, q_lsb, {md_q[1:0], md_qm1});
      end
      n_cmp++;
      if (cnt_done !== (md_cnt == W / 2)) begin
        n_err++;
        $display("FAIL model_cnt_done t=%0t actual=%b required=%b", $time, cnt_done, (md_cnt == W / 2));
      end
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Strobe byte: bit i drives ci.
  task automatic cyc(input logic [7:0] c, input logic [W-1:0] d);
    @(negedge clk);
    {c7, c6, c5, c4, c3, c2, c1, c0} = c;
    inbus = d;
    @(posedge clk);
    #1;
    {c7, c6, c5, c4, c3, c2, c1, c0} = 8'h00;
  endtask

  task automatic booth_iter();
    logic [2:0] w;
    logic [7:0] c;
    w = {md_q[1:0], md_qm1};
    case (w)
      3'b001, 3'b010: c = 8'h04;
      3'b011:         c = 8'h14;
      3'b100:         c = 8'h1C;
      3'b101, 3'b110: c = 8'h0C;
      default:        c = 8'h00;
    endcase
    if (c != 8'h00) cyc(c, '0);
    cyc(8'h20, '0);
  endtask

  task automatic mult(input string name, input logic [W-1:0] m, input logic [W-1:0] q,
                      input logic [W-1:0] hi, input logic [W-1:0] lo);
    cyc(8'h02, m);
    cyc(8'h01, q);
    for (int i = 0; i < W / 2; i++) booth_iter();
    check({name, "_cnt_done"}, 16'(cnt_done), 16'h1);
    cyc(8'h40, '0);
    check({name, "_hi"}, 16'(outbus), 16'(hi));
    cyc(8'h80, '0);
    check({name, "_lo"}, 16'(outbus), 16'(lo));
  endtask

  initial begin
    n_cmp = 0; n_err = 0; chk_en = 1'b0;
    reset = 1'b0; inbus = '0;
    {c7, c6, c5, c4, c3, c2, c1, c0} = 8'hFF;
    inbus = 8'hA5;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    check("rst_outbus", 16'(outbus), 16'h0);
    check("rst_q_lsb", 16'(q_lsb), 16'h0);
    check("rst_cnt_done", 16'(cnt_done), 16'h0);
    {c7, c6, c5, c4, c3, c2, c1, c0} = 8'h00;
    @(negedge clk);
    reset = 1'b1;

    cyc(8'h01, 8'h06);
    check("load_q_lsb", 16'(q_lsb), 16'h4);

    mult("mul_7x3", 8'h07, 8'h03, 8'h00, 8'h15);
    cyc(8'h00, '0);
    check("outbus_hold", 16'(outbus), 16'h15);
    cyc(8'hC0, '0);
    check("c6_over_c7", 16'(outbus), 16'h00);

    mult("mul_m5x6", 8'hFB, 8'h06, 8'hFF, 8'hE2);
    mult("mul_80x80", 8'h80, 8'h80, 8'h40, 8'h00);
    mult("mul_m1xm1", 8'hFF, 8'hFF, 8'h00, 8'h01);
    mult("mul_127xm128", 8'h7F, 8'h80, 8'hC0, 8'h80);

    cyc(8'h03, 8'h05);
    for (int i = 0; i < W / 2; i++) booth_iter();
    cyc(8'h40, '0);
    check("c0c1_same_hi", 16'(outbus), 16'h00);
    cyc(8'h80, '0);
    check("c0c1_same_lo", 16'(outbus), 16'h19);

    cyc(8'h02, 8'h03);
    cyc(8'h01, 8'h00);
    cyc(8'h34, '0);
    check("comb_cnt1", 16'(cnt_done), 16'h0);
    cyc(8'h40, '0);
    check("comb_a", 16'(outbus), 16'h01);
    cyc(8'h80, '0);
    check("comb_q", 16'(outbus), 16'h80);
    cyc(8'h20, '0);
    cyc(8'h20, '0);
    check("comb_cnt3", 16'(cnt_done), 16'h0);
    cyc(8'h20, '0);
    check("comb_cnt4", 16'(cnt_done), 16'h1);
    cyc(8'h20, '0);
    check("cnt_saturate", 16'(cnt_done), 16'h1);
    cyc(8'h18, '0);
    check("c3c4_ignored_qlsb", 16'(q_lsb), 16'h3);
    cyc(8'h80, '0);
    check("c3c4_ignored_q", 16'(outbus), 16'h01);

    cyc(8'h02, 8'h07);
    cyc(8'h01, 8'h03);
    booth_iter();
    booth_iter();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("midrst_outbus", 16'(outbus), 16'h0);
    check("midrst_q_lsb", 16'(q_lsb), 16'h0);
    check("midrst_cnt_done", 16'(cnt_done), 16'h0);
    @(negedge clk);
    reset = 1'b1;
    cyc(8'h40, '0);
    check("midrst_a_zero", 16'(outbus), 16'h0);
    mult("mul_after_rst", 8'h07, 8'h03, 8'h00, 8'h15);

    @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
